// File: rtl/fxp_pkg.sv
// Shared fixed-point helpers: FSM state encoding, saturation limits and a
// fixed-point-to-real conversion for benches.
package fxp_pkg;

   typedef enum logic {
      ST_ACCUM = 1'b0,
      ST_HOLD  = 1'b1
   } state_t;

   function automatic int sat_max(input int w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int sat_min(input int w);
      return -(1 << (w - 1));
   endfunction

   function automatic real fxp_to_real(input longint v, input int wf);
      return real'(v) / (2.0 ** wf);
   endfunction

endpackage

// File: rtl/fxp_int_accum_if.sv
// Sample-in / frame-out stream bundle for fxp_int_accum; slave is the block side.
interface fxp_int_accum_if #(
   parameter int WI = 3,
   parameter int WF = 4,
   parameter int WA = 6
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WI+WF-1:0]     in_data;
   logic                 in_oflag;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [WA-1:0] out_sum;
   logic                 out_ovf;
   logic                 out_frac_err;

   modport slave (
      input  in_valid, in_data, in_oflag, out_ready,
      output in_ready, out_valid, out_sum, out_ovf, out_frac_err
   );

   modport master (
      output in_valid, in_data, in_oflag, out_ready,
      input  in_ready, out_valid, out_sum, out_ovf, out_frac_err
   );
endinterface

// File: rtl/fxp_sat_add.sv
// W-bit signed saturating adder; sat flags that the result was clamped.
module fxp_sat_add
   import fxp_pkg::*;
#(
   parameter int W = 6
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] y,
   output logic                sat
);
   logic signed [W:0] s;

   // One guard bit: overflow shows up as disagreeing top two bits.
   assign s = {a[W-1], a} + {b[W-1], b};

   always_comb begin
      y   = s[W-1:0];
      sat = 1'b0;
      if (s[W] != s[W-1]) begin
         sat = 1'b1;
         y   = s[W] ? W'(sat_min(W)) : W'(sat_max(W));
      end
   end
endmodule

// File: rtl/fxp_int_accum.sv
// Accumulates integer parts of N ceil results into a saturating frame sum.
// Optional FXP_ACC_FRAC_CHK_EN flags accepted samples with nonzero fraction bits.
module fxp_int_accum
   import fxp_pkg::*;
#(
   parameter int WI = 3,
   parameter int WF = 4,
   parameter int N  = 4,
   parameter int WA = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   fxp_int_accum_if.slave   io
);
   localparam int CW = $clog2(N + 1);

   state_t               state;
   logic [CW-1:0]        cnt;
   logic signed [WA-1:0] acc;
   logic signed [WA-1:0] ip;
   logic signed [WA-1:0] sum;
   logic                 sat;
   logic                 ovf;
   logic                 frac_err;
   logic                 frac_hit;
   logic                 in_ready_q;
   logic                 out_valid_q;
   logic                 accept;

   assign ip     = WA'($signed(io.in_data[WI+WF-1:WF]));
   assign accept = io.in_valid & in_ready_q;

`ifdef FXP_ACC_FRAC_CHK_EN
   assign frac_hit = |io.in_data[WF-1:0];
`else
   logic unused_frac;
   assign unused_frac = ^io.in_data[WF-1:0];
   assign frac_hit    = 1'b0;
`endif

   fxp_sat_add #(.W(WA)) u_add (
      .a   (acc),
      .b   (ip),
      .y   (sum),
      .sat (sat)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= ST_ACCUM;
         acc         <= '0;
         cnt         <= '0;
         ovf         <= 1'b0;
         frac_err    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state)
            ST_ACCUM: if (accept) begin
               acc      <= sum;
               ovf      <= ovf | sat | io.in_oflag;
               frac_err <= frac_err | frac_hit;
               cnt      <= cnt + 1'b1;
               if (cnt == CW'(N - 1)) begin
                  state       <= ST_HOLD;
                  in_ready_q  <= 1'b0;
                  out_valid_q <= 1'b1;
               end
            end
            // Clearing on release costs one bubble before the next frame.
            ST_HOLD: if (io.out_ready) begin
               state       <= ST_ACCUM;
               acc         <= '0;
               cnt         <= '0;
               ovf         <= 1'b0;
               frac_err    <= 1'b0;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
            default: state <= ST_ACCUM;
         endcase
      end
   end

   assign io.in_ready     = in_ready_q;
   assign io.out_valid    = out_valid_q;
   assign io.out_sum      = acc;
   assign io.out_ovf      = ovf;
   assign io.out_frac_err = frac_err;
endmodule

// File: tb/tb_fxp_int_accum.sv
// Directed bench: WA=6 and WA=4 instances driven with the same sample stream.
module tb_fxp_int_accum;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [6:0] in_data;
   logic       in_oflag;
   logic       out_ready;
   int         checks = 0;
   int         errors = 0;

   fxp_int_accum_if #(.WI(3), .WF(4), .WA(6)) ifa ();
   fxp_int_accum_if #(.WI(3), .WF(4), .WA(4)) ifb ();

   assign ifa.in_valid  = in_valid;
   assign ifa.in_data   = in_data;
   assign ifa.in_oflag  = in_oflag;
   assign ifa.out_ready = out_ready;
   assign ifb.in_valid  = in_valid;
   assign ifb.in_data   = in_data;
   assign ifb.in_oflag  = in_oflag;
   assign ifb.out_ready = out_ready;

   fxp_int_accum #(.WI(3), .WF(4), .N(4), .WA(6)) dut_a (.clk(clk), .rst_n(rst_n), .io(ifa));
   fxp_int_accum #(.WI(3), .WF(4), .N(4), .WA(4)) dut_b (.clk(clk), .rst_n(rst_n), .io(ifb));

   always #5 clk = ~clk;

   // Called at a negedge; returns at the negedge after the sample is taken.
   task automatic push(input logic [6:0] d, input logic of);
      int t = 0;
      in_valid = 1'b1; in_data = d; in_oflag = of;
      while (!ifa.in_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin
         errors++;
         $display("FAIL push_timeout got in_ready=0 exp in_ready=1");
      end
      @(negedge clk);
      in_valid = 1'b0; in_oflag = 1'b0;
   endtask

   task automatic pop();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++;
      if (ifa.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL pop_release got out_valid=%b exp 0", ifa.out_valid);
      end
   endtask

   task automatic chk_frame(input string nm, input logic signed [5:0] sa,
                            input logic oa, input logic signed [3:0] sb, input logic ob);
      checks++;
      if (ifa.out_valid !== 1'b1 || ifa.out_sum !== sa || ifa.out_ovf !== oa) begin
         errors++;
         $display("FAIL %s_a got v=%b sum=%0d ovf=%b exp v=1 sum=%0d ovf=%b",
                  nm, ifa.out_valid, ifa.out_sum, ifa.out_ovf, sa, oa);
      end
      checks++;
      if (ifb.out_valid !== 1'b1 || ifb.out_sum !== sb || ifb.out_ovf !== ob) begin
         errors++;
         $display("FAIL %s_b got v=%b sum=%0d ovf=%b exp v=1 sum=%0d ovf=%b",
                  nm, ifb.out_valid, ifb.out_sum, ifb.out_ovf, sb, ob);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_oflag = 1'b0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (ifa.out_valid !== 1'b0 || ifa.in_ready !== 1'b1 || ifa.out_sum !== 6'sd0 ||
          ifa.out_ovf !== 1'b0 || ifa.out_frac_err !== 1'b0) begin
         errors++;
         $display("FAIL reset got v=%b rdy=%b sum=%0d ovf=%b fe=%b exp 0 1 0 0 0",
                  ifa.out_valid, ifa.in_ready, ifa.out_sum, ifa.out_ovf, ifa.out_frac_err);
      end
   endtask

   task automatic test_basic();
      push(7'b001_0000, 0); push(7'b011_0000, 0); push(7'b110_0000, 0);
      checks++;
      if (ifa.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_early got out_valid=%b exp 0", ifa.out_valid);
      end
      push(7'b001_0000, 0);
      chk_frame("basic", 6'sd3, 1'b0, 4'sd3, 1'b0);
      pop();
   endtask

   task automatic test_saturation();
      repeat (4) push(7'b100_0000, 0);
      chk_frame("sat_neg", -6'sd16, 1'b0, -4'sd8, 1'b1);
      pop();
      repeat (4) push(7'b011_0000, 0);
      chk_frame("sat_pos", 6'sd12, 1'b0, 4'sd7, 1'b1);
      pop();
   endtask

   task automatic test_backpressure();
      logic signed [5:0] held;
      repeat (4) push(7'b010_0000, 0);
      held = 6'sd8;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0] ? 1'b0 : 1'b1; in_data = 7'b011_0000;
         @(negedge clk);
         checks++;
         if (ifa.out_valid !== 1'b1 || ifa.in_ready !== 1'b0 || ifa.out_sum !== held ||
             ifa.out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold got v=%b rdy=%b sum=%0d ovf=%b exp v=1 rdy=0 sum=%0d ovf=0",
                     ifa.out_valid, ifa.in_ready, ifa.out_sum, ifa.out_ovf, held);
         end
      end
      in_valid = 1'b0;
      pop();
      repeat (4) push(7'b001_0000, 0);
      chk_frame("bp_next", 6'sd4, 1'b0, 4'sd4, 1'b0);
      pop();
   endtask

   task automatic test_ceil_ovf();
      push(7'b001_0000, 0); push(7'b001_0000, 1); push(7'b001_0000, 0); push(7'b001_0000, 0);
      chk_frame("oflag", 6'sd4, 1'b1, 4'sd4, 1'b1);
      pop();
      repeat (4) push(7'b001_0000, 0);
      chk_frame("oflag_clr", 6'sd4, 1'b0, 4'sd4, 1'b0);
      pop();
   endtask

   task automatic test_reset_midframe();
      push(7'b001_0000, 0); push(7'b001_0000, 0);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) push(7'b001_0000, 0);
      checks++;
      if (ifa.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_early got out_valid=%b exp 0", ifa.out_valid);
      end
      push(7'b001_0000, 0);
      chk_frame("rst_mid", 6'sd4, 1'b0, 4'sd4, 1'b0);
      pop();
   endtask

   task automatic test_frac();
      logic fe_exp;
`ifdef FXP_ACC_FRAC_CHK_EN
      fe_exp = 1'b1;
`else
      fe_exp = 1'b0;
`endif
      push(7'b000_1000, 0);
      repeat (3) push(7'b001_0000, 0);
      chk_frame("frac", 6'sd3, 1'b0, 4'sd3, 1'b0);
      checks++;
      if (ifa.out_frac_err !== fe_exp) begin
         errors++;
         $display("FAIL frac_err got %b exp %b", ifa.out_frac_err, fe_exp);
      end
      pop();
      repeat (4) push(7'b001_0000, 0);
      checks++;
      if (ifa.out_frac_err !== 1'b0) begin
         errors++;
         $display("FAIL frac_clr got %b exp 0", ifa.out_frac_err);
      end
      pop();
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_saturation();
      test_backpressure();
      test_ceil_ovf();
      test_reset_midframe();
      test_frac();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
